// File: rtl/wb_memtest_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_memtest_pkg : shared types and pattern generator for wb_memtest_master
// Revision: 1.0
// ---------------------------------------------------------------------------
package wb_memtest_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WGAP = 3'd2,
    RD   = 3'd3,
    RGAP = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOTH  = 2'd2
  } mode_t;

  // idx arrives zero-extended, so the shifted copy truncates to 32 bits
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] idx);
    return seed ^ idx ^ {idx[23:0], 8'h00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_memtest_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_memtest_cmp : masked read-data compare, saturating error count, first-error capture
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_memtest_cmp
  import wb_memtest_pkg::*;
#(
  parameter int aw = 8
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [31:0]   i_rdt,
  input  logic [31:0]   i_seed,
  input  logic [3:0]    i_mask,
  input  logic [aw-3:0] i_idx,
  output logic [15:0]   o_err_cnt,
  output logic [aw-3:0] o_first_err_adr
);

  localparam logic [15:0] c_err_max = 16'hFFFF;

  logic [31:0] w_lane_mask;
  logic [31:0] w_diff;
  logic        w_mismatch;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_lane_mask[8*g +: 8] = {8{i_mask[g]}};
  end

  assign w_diff     = (i_rdt ^ pattern(i_seed, 32'(i_idx))) & w_lane_mask;
  assign w_mismatch = i_valid && (w_diff != '0);

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_err_cnt       <= '0;
      o_first_err_adr <= '0;
    end else if (i_clear) begin
      o_err_cnt       <= '0;
      o_first_err_adr <= '0;
    end else if (w_mismatch) begin
      if (o_err_cnt != c_err_max) o_err_cnt <= o_err_cnt + 16'd1;
      if (o_err_cnt == '0) o_first_err_adr <= i_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_memtest_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_memtest_master : Wishbone classic fill/check self-test initiator for the word RAM
// Optional ack timeout: define WB_MEMTEST_ACK_TIMEOUT_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_memtest_master
  import wb_memtest_pkg::*;
#(
  parameter int depth   = 256,
  parameter int aw      = $clog2(depth),
  parameter int TIMEOUT = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_mode,
  input  logic [aw-3:0] i_base,
  input  logic [aw-2:0] i_len,
  input  logic [31:0]   i_seed,
  input  logic [3:0]    i_mask,
  output logic [aw-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [15:0]   o_err_cnt,
  output logic [aw-3:0] o_first_err_adr,
  output logic          o_timeout
);

  localparam logic [aw-3:0] c_idx_one = 1;
  localparam logic [aw-2:0] c_len_one = 1;

  state_t        r_state, w_next;
  logic [31:0]   r_seed;
  logic [3:0]    r_mask;
  logic [1:0]    r_mode;
  logic [aw-3:0] r_base, r_idx;
  logic [aw-2:0] r_len, r_left;
  logic          r_pass;
  logic          w_xfer, w_ack, w_accept, w_do_read, w_to_hit, w_pass_next;

  assign w_xfer    = (r_state == WR) || (r_state == RD);
  assign w_ack     = w_xfer && i_wb_ack;
  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_do_read = (r_mode != MODE_FILL);

`ifdef WB_MEMTEST_ACK_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)                r_to_cnt <= '0;
    else if (w_xfer && !i_wb_ack)   r_to_cnt <= r_to_cnt + 16'd1;
    else                            r_to_cnt <= '0;
  end

  assign w_to_hit = w_xfer && !i_wb_ack && (r_to_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)   r_timeout <= 1'b0;
    else if (w_accept) r_timeout <= 1'b0;
    else if (w_to_hit) r_timeout <= 1'b1;
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_to_hit         = 1'b0;
  assign o_timeout        = 1'b0;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_wb_cyc = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_sel = 4'h0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0)              w_next = DONE;
          else if (i_mode == MODE_CHECK) w_next = RD;
          else                           w_next = WR;
        end
      end
      WR: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_sel = r_mask;
        o_wb_adr = {r_idx, 2'b00};
        o_wb_dat = pattern(r_seed, 32'(r_idx));
        if (i_wb_ack)      w_next = WGAP;
        else if (w_to_hit) w_next = DONE;
      end
      WGAP: begin
        if (r_left != '0)  w_next = WR;
        else if (w_do_read) w_next = RD;
        else                w_next = DONE;
      end
      RD: begin
        o_wb_cyc = 1'b1;
        o_wb_sel = 4'hF;
        o_wb_adr = {r_idx, 2'b00};
        if (i_wb_ack)      w_next = RGAP;
        else if (w_to_hit) w_next = DONE;
      end
      RGAP: begin
        if (r_left != '0) w_next = RD;
        else              w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign o_wb_stb = o_wb_cyc;

  // Both passes walk the same region: on leaving the last write gap the walk rewinds to base
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_seed <= '0;
      r_mask <= '0;
      r_mode <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_left <= '0;
    end else if (w_accept) begin
      r_seed <= i_seed;
      r_mask <= i_mask;
      r_mode <= i_mode;
      r_base <= i_base;
      r_len  <= i_len;
      r_idx  <= i_base;
      r_left <= i_len;
    end else if (w_ack) begin
      r_idx  <= r_idx + c_idx_one;
      r_left <= r_left - c_len_one;
    end else if ((r_state == WGAP) && (r_left == '0)) begin
      r_idx  <= r_base;
      r_left <= r_len;
    end
  end

  assign w_pass_next = (r_state == IDLE) || ((o_err_cnt == '0) && !w_to_hit);

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)                              r_pass <= 1'b0;
    else if ((w_next == DONE) && (r_state != DONE)) r_pass <= w_pass_next;
    else if (w_accept)                            r_pass <= 1'b0;
  end

  assign o_pass = r_pass;
  assign o_done = (r_state == DONE);
  assign o_busy = (r_state == WR) || (r_state == WGAP) || (r_state == RD) || (r_state == RGAP);

  wb_memtest_cmp #(
    .aw (aw)
  ) u_cmp (
    .i_wb_clk        (i_wb_clk),
    .i_wb_rst_n      (i_wb_rst_n),
    .i_clear         (w_accept),
    .i_valid         ((r_state == RD) && i_wb_ack),
    .i_rdt           (i_wb_rdt),
    .i_seed          (r_seed),
    .i_mask          (r_mask),
    .i_idx           (r_idx),
    .o_err_cnt       (o_err_cnt),
    .o_first_err_adr (o_first_err_adr)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_memtest_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_memtest_master : directed self-checking bench with a behavioural word-RAM slave
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_wb_memtest_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic [1:0]  mode;
  logic [5:0]  base;
  logic [6:0]  len;
  logic [31:0] seed;
  logic [3:0]  mask;
  logic [7:0]  adr;
  logic [31:0] dat, rdt;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [5:0]  first_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_memtest_master #(
    .depth   (256),
    .aw      (8),
    .TIMEOUT (16)
  ) dut (
    .i_wb_clk        (clk),
    .i_wb_rst_n      (rst_n),
    .i_start         (start),
    .i_mode          (mode),
    .i_base          (base),
    .i_len           (len),
    .i_seed          (seed),
    .i_mask          (mask),
    .o_wb_adr        (adr),
    .o_wb_dat        (dat),
    .o_wb_sel        (sel),
    .o_wb_we         (we),
    .o_wb_cyc        (cyc),
    .o_wb_stb        (stb),
    .i_wb_rdt        (rdt),
    .i_wb_ack        (ack),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_err_cnt       (err_cnt),
    .o_first_err_adr (first_err),
    .o_timeout       (timeout)
  );

  // word RAM slave: ack after ack_lat wait cycles (0 = same cycle), backdoor xor corruption
  logic [31:0] mem [0:63];
  int          ack_lat   = 0;
  logic        ack_block = 1'b0;
  int          wait_cnt  = 0;
  logic        bd_we     = 1'b0;
  logic [5:0]  bd_idx    = '0;
  logic [31:0] bd_xor    = '0;

  assign ack = cyc && stb && !ack_block && (wait_cnt >= ack_lat);
  assign rdt = mem[adr[7:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= mem[bd_idx] ^ bd_xor;
    else if (cyc && stb && we && ack)
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[adr[7:2]][8*b +: 8] <= dat[8*b +: 8];
    if (cyc && stb && !ack) wait_cnt <= wait_cnt + 1;
    else                    wait_cnt <= 0;
  end

  // bus monitor
  int          tick = 0, cyc_cycles = 0, cyc_rises = 0, stb_viol = 0, stab_viol = 0;
  logic        prev_cyc = 1'b0, prev_wait = 1'b0;
  logic [44:0] prev_bus = '0;
  logic [6:0]  trace [$];

  always @(posedge clk) tick <= tick + 1;

  always @(negedge clk) begin
    if (cyc) cyc_cycles <= cyc_cycles + 1;
    if (cyc && !prev_cyc) cyc_rises <= cyc_rises + 1;
    if (stb !== cyc) stb_viol <= stb_viol + 1;
    if (prev_wait && cyc && ({we, sel, adr, dat} !== prev_bus)) stab_viol <= stab_viol + 1;
    if (cyc && ack) trace.push_back({we, adr[7:2]});
    prev_cyc  <= cyc;
    prev_wait <= cyc && !ack;
    prev_bus  <= {we, sel, adr, dat};
  end

  function automatic logic [31:0] pat(input logic [31:0] s, input int k);
    return s ^ 32'(k) ^ (32'(k) << 8);
  endfunction

  int t0, c0, r0, q0;

  task automatic start_cmd(input logic [1:0] m, input logic [5:0] b, input logic [6:0] l,
                           input logic [31:0] s, input logic [3:0] k);
    @(negedge clk);
    mode = m; base = b; len = l; seed = s; mask = k; start = 1'b1;
    t0 = tick; c0 = cyc_cycles; r0 = cyc_rises; q0 = trace.size();
    @(negedge clk);
    start = 1'b0;
  endtask

  // cycle number of the done pulse, counting the start cycle as 1; -1 if never seen
  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        n = tick - t0 + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic corrupt(input logic [5:0] idx, input logic [31:0] x);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_xor = x;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    start = 0; mode = 0; base = 0; len = 0; seed = 0; mask = 0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({cyc, stb, we, busy, done, pass, timeout} !== 7'b0) begin fails++;
      $display("FAIL reset_ctrl: got %b want 0000000", {cyc, stb, we, busy, done, pass, timeout}); end
    checks++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
    checks++; if (first_err !== 6'h0) begin fails++; $display("FAIL reset_first_err: got %h want 00", first_err); end
    checks++; if ({adr, dat, sel} !== 44'h0) begin fails++; $display("FAIL reset_bus: adr %h dat %h sel %h want 0", adr, dat, sel); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int n, bad;
    ack_lat = 0;
    start_cmd(2'd0, 6'd0, 7'd64, 32'hA5A5_0000, 4'hF);
    wait_done(400, n);
    checks++; if (n != 130) begin fails++; $display("FAIL fill_done_cycle: got %0d want 130", n); end
    checks++; if ({pass, busy, err_cnt} !== {1'b1, 1'b0, 16'h0}) begin fails++;
      $display("FAIL fill_status: pass %b busy %b err %h want 1 0 0000", pass, busy, err_cnt); end
    checks++; if (cyc_cycles - c0 != 64) begin fails++; $display("FAIL fill_cyc_cycles: got %0d want 64", cyc_cycles - c0); end
    checks++; if (cyc_rises - r0 != 64) begin fails++; $display("FAIL fill_cyc_bursts: got %0d want 64", cyc_rises - r0); end
    bad = 0;
    for (int k = 0; k < 64; k++) if (mem[k] !== pat(32'hA5A5_0000, k)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL fill_ram_content: got %0d bad words want 0", bad); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL fill_done_pulse: done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_wrap;
    int n, bad;
    logic [6:0] expv;
    start_cmd(2'd2, 6'd60, 7'd8, 32'h1234_5678, 4'hF);
    wait_done(200, n);
    checks++; if (n != 34) begin fails++; $display("FAIL wrap_done_cycle: got %0d want 34", n); end
    checks++; if ({pass, err_cnt, first_err} !== {1'b1, 16'h0, 6'h0}) begin fails++;
      $display("FAIL wrap_status: pass %b err %h first %h want 1 0000 00", pass, err_cnt, first_err); end
    checks++; if (trace.size() - q0 != 16) begin fails++; $display("FAIL wrap_xfer_count: got %0d want 16", trace.size() - q0); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      expv = {(i < 8), 6'((60 + (i % 8)) % 64)};
      if ((q0 + i >= trace.size()) || (trace[q0 + i] !== expv)) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL wrap_addr_seq: got %0d wrong entries want 0", bad); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[(60 + i) % 64] !== pat(32'h1234_5678, (60 + i) % 64)) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL wrap_ram_content: got %0d bad words want 0", bad); end
  endtask

  task automatic test_mismatch;
    int n;
    start_cmd(2'd0, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'hF); wait_done(100, n);
    corrupt(6'd5, 32'h0000_FF00);
    start_cmd(2'd1, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'hF); wait_done(100, n);
    checks++; if (n != 34) begin fails++; $display("FAIL chk_done_cycle: got %0d want 34", n); end
    checks++; if ({err_cnt, first_err, pass} !== {16'd1, 6'd5, 1'b0}) begin fails++;
      $display("FAIL chk_one_err: err %0d first %0d pass %b want 1 5 0", err_cnt, first_err, pass); end
    start_cmd(2'd1, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'hD); wait_done(100, n);
    checks++; if ({err_cnt, first_err, pass} !== {16'd0, 6'd0, 1'b1}) begin fails++;
      $display("FAIL chk_mask_d: err %0d first %0d pass %b want 0 0 1", err_cnt, first_err, pass); end
    corrupt(6'd9, 32'hFF00_0000);
    start_cmd(2'd1, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'hF); wait_done(100, n);
    checks++; if ({err_cnt, first_err, pass} !== {16'd2, 6'd5, 1'b0}) begin fails++;
      $display("FAIL chk_two_err: err %0d first %0d pass %b want 2 5 0", err_cnt, first_err, pass); end
    start_cmd(2'd1, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'h0); wait_done(100, n);
    checks++; if ({err_cnt, pass} !== {16'd0, 1'b1}) begin fails++;
      $display("FAIL chk_mask_0: err %0d pass %b want 0 1", err_cnt, pass); end
    start_cmd(2'd0, 6'd0, 7'd16, 32'h0000_0000, 4'h0); wait_done(100, n);
    checks++; if (cyc_cycles - c0 != 16) begin fails++; $display("FAIL fill_mask_0_cycles: got %0d want 16", cyc_cycles - c0); end
    start_cmd(2'd1, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'h2); wait_done(100, n);
    checks++; if ({err_cnt, first_err, pass} !== {16'd1, 6'd5, 1'b0}) begin fails++;
      $display("FAIL fill_mask_0_kept: err %0d first %0d pass %b want 1 5 0", err_cnt, first_err, pass); end
    start_cmd(2'd3, 6'd0, 7'd2, 32'hDEAD_BEEF, 4'hF); wait_done(100, n);
    checks++; if ((trace.size() - q0 != 4) || (trace[q0] !== 7'h40) || (trace[q0 + 2] !== 7'h00)) begin fails++;
      $display("FAIL mode3_as_both: got %0d xfers want 4 (2 wr then 2 rd)", trace.size() - q0); end
  endtask

  task automatic test_len0;
    int n;
    start_cmd(2'd2, 6'd7, 7'd0, 32'h1111_2222, 4'hF);
    wait_done(10, n);
    checks++; if (n != 2) begin fails++; $display("FAIL len0_done_cycle: got %0d want 2", n); end
    checks++; if (cyc_cycles - c0 != 0) begin fails++; $display("FAIL len0_no_bus: got %0d cyc cycles want 0", cyc_cycles - c0); end
    checks++; if ({pass, err_cnt, first_err} !== {1'b1, 16'h0, 6'h0}) begin fails++;
      $display("FAIL len0_status: pass %b err %h first %h want 1 0000 00", pass, err_cnt, first_err); end
  endtask

  task automatic test_wait_states;
    int n, s0, bad, q1;
    ack_lat = 3;
    s0 = stab_viol;
    start_cmd(2'd0, 6'd10, 7'd4, 32'h0F0F_3C3C, 4'hF);
    repeat (3) @(negedge clk);
    start = 1'b1; base = 6'd40; mode = 2'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, n);
    checks++; if (n != 22) begin fails++; $display("FAIL wait_done_cycle: got %0d want 22", n); end
    checks++; if (stab_viol - s0 != 0) begin fails++; $display("FAIL wait_bus_stable: got %0d changes want 0", stab_viol - s0); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if ((q0 + i >= trace.size()) || (trace[q0 + i] !== {1'b1, 6'(10 + i)})) bad++;
      if (mem[10 + i] !== pat(32'h0F0F_3C3C, 10 + i)) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL wait_xfers: got %0d wrong want 0", bad); end
    q1 = trace.size();
    repeat (6) @(negedge clk);
    checks++; if ((trace.size() != q1) || (busy !== 1'b0) || (q1 - q0 != 4)) begin fails++;
      $display("FAIL busy_start_ignored: xfers %0d busy %b want 4 0", trace.size() - q0, busy); end
    checks++; if (stb_viol != 0) begin fails++; $display("FAIL stb_eq_cyc: got %0d cycles differing want 0", stb_viol); end
  endtask

  task automatic test_reset_mid;
    logic in_rd;
    in_rd = 1'b0;
    start_cmd(2'd1, 6'd0, 7'd16, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (cyc && !we) begin in_rd = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (in_rd !== 1'b1) begin fails++; $display("FAIL rstmid_reach_rd: got %b want 1", in_rd); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({cyc, stb, busy} !== 3'b000) begin fails++;
      $display("FAIL rstmid_async_drop: cyc %b stb %b busy %b want 0 0 0", cyc, stb, busy); end
    @(negedge clk); rst_n = 1'b1; ack_lat = 0;
    @(negedge clk);
    checks++; if ({cyc, done, err_cnt} !== {1'b0, 1'b0, 16'h0}) begin fails++;
      $display("FAIL rstmid_idle: cyc %b done %b err %h want 0 0 0000", cyc, done, err_cnt); end
  endtask

`ifdef WB_MEMTEST_ACK_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    ack_block = 1'b1;
    start_cmd(2'd0, 6'd0, 7'd4, 32'h5555_AAAA, 4'hF);
    wait_done(100, n);
    checks++; if (n != 18) begin fails++; $display("FAIL to_done_cycle: got %0d want 18", n); end
    checks++; if (cyc_cycles - c0 != 16) begin fails++; $display("FAIL to_cyc_cycles: got %0d want 16", cyc_cycles - c0); end
    checks++; if ({timeout, pass} !== 2'b10) begin fails++; $display("FAIL to_status: timeout %b pass %b want 1 0", timeout, pass); end
    ack_block = 1'b0;
    start_cmd(2'd0, 6'd0, 7'd0, 32'h0, 4'hF);
    wait_done(10, n);
    checks++; if ({timeout, pass} !== 2'b01) begin fails++; $display("FAIL to_cleared: timeout %b pass %b want 0 1", timeout, pass); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_mismatch();
    test_len0();
    test_wait_states();
    test_reset_mid();
`ifdef WB_MEMTEST_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/wb_memtest_master.md
Name: wb_memtest_master

Overview:
Wishbone classic initiator that drives the 32-bit word RAM slave. Per command it fills a word region with a deterministic pattern, reads it back and checks it, or does both. Byte-lane masks exercise the slave's per-byte write enables. Sits beside the RAM as a built-in self-test and scrub engine.

Parameters:
depth, 256, RAM size in bytes, matching the slave; words = depth/4
aw, $clog2(depth), byte-address width
TIMEOUT, 16, ack wait limit in cycles; used only with the optional feature

Ports:
i_wb_clk  in  1  clock
i_wb_rst_n  in  1  asynchronous active-low reset
i_start  in  1  command strobe; accepted only in IDLE
i_mode  in  2  0=fill, 1=check, 2=fill then check, 3=reserved, treated as 2
i_base  in  aw-2  first word index
i_len  in  aw-1  word count, 0..depth/4
i_seed  in  32  pattern seed
i_mask  in  4  byte lanes: used as o_wb_sel in fill, compare mask in check
o_wb_adr  out  aw  byte address = {word_idx, 2'b00}
o_wb_dat  out  32  write data
o_wb_sel  out  4  byte select
o_wb_we  out  1  write enable
o_wb_cyc  out  1  cycle
o_wb_stb  out  1  strobe; always equal to o_wb_cyc
i_wb_rdt  in  32  read data, valid when i_wb_ack=1
i_wb_ack  in  1  slave acknowledge
o_busy  out  1  command in progress
o_done  out  1  one-cycle pulse at command end
o_pass  out  1  1 when last command finished with o_err_cnt==0 and no timeout
o_err_cnt  out  16  mismatching words, saturates at 16'hFFFF
o_first_err_adr  out  aw-2  word index of the first mismatch
o_timeout  out  1  sticky until next accepted start

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, counters cleared. Reset mid-transfer drops cyc/stb immediately.
- Pattern for word index k: pat(k) = i_seed ^ {{(34-aw){1'b0}}, k} ^ {k, 8'h0}, truncated to 32 bits. Seed, mask, mode, base and len are latched on start.
- Word index: (base + n) mod (depth/4). Regions past the top wrap to word 0.
- FSM states: IDLE, WR, WGAP, RD, RGAP, DONE.
- IDLE: on i_start, clear o_err_cnt, o_first_err_adr, o_timeout and o_pass; set o_busy.
  - len==0: go to DONE with no bus activity.
  - Otherwise go to WR (mode 0/2) or RD (mode 1).
- WR: cyc=stb=we=1, sel=mask, dat=pat(idx). Outputs are held stable until ack is sampled high. Then go to WGAP.
- WGAP: cyc=stb=0 for exactly one cycle. Next: WR for the next word, RD at word 0 of the region (mode 2 after the last write), or DONE.
- RD: cyc=stb=1, we=0, sel=4'hF. On ack, compare ((i_wb_rdt ^ pat(idx)) & lane mask expanded from i_mask).
  - On nonzero result: increment o_err_cnt (saturating).
  - On the first mismatch only: load o_first_err_adr.
  - Then go to RGAP.
- RGAP: one idle cycle, then RD or DONE.
- DONE: o_done=1 for one cycle, o_pass updated, o_busy=0 in the same cycle, then IDLE. The next start is accepted the following cycle.
- Write-only commands (mode 0) finish with o_pass=1 unless timed out.
- i_start while busy is ignored. Ack outside RD/WR is ignored.
- Throughput: 2 cycles per word against a zero-wait slave. Latency from start to done = 2*words + 2 cycles (+1 for the DONE state).
- i_mask==0: fill writes nothing (sel=0, bus cycles still issued). Check reports 0 errors.

Optional Feature:
- Macro: WB_MEMTEST_ACK_TIMEOUT_EN.
- When defined: in WR/RD a counter runs. If ack is still absent after TIMEOUT cycles, drop cyc/stb, set o_timeout, go to DONE with o_pass=0.
- When undefined: waits for ack indefinitely; o_timeout tied 0; the TIMEOUT parameter is unused.

Decomposition:
- Package wb_memtest_pkg holds: state enum, mode enum (MODE_FILL, MODE_CHECK, MODE_BOTH), and function pattern(seed, idx).
- One sub-module, wb_memtest_cmp: combinational masked compare plus the saturating error counter and first-error capture register.

Test Plan:
- depth=256, fill, base=0, len=64, seed=32'hA5A5_0000, mask=4'hF -> 64 write cycles, one idle cycle between them. The RAM holds pat(k) at every word. Done at cycle 130.
- Mode 2, base=60, len=8 -> addresses 60..63 then 0..3 (wrap). err_cnt=0, pass=1.
- Fill mask=4'hF, then corrupt word 5 byte 1 through the slave, then check base=0 len=16 mask=4'hF -> err_cnt=1, first_err_adr=5, pass=0. The same check with mask=4'hD gives err_cnt=0.
- Slave with 3-cycle ack latency -> stb/adr/dat held stable until ack; each word takes 5 cycles. Start pulsed mid-command is ignored.
- len=0 -> done one cycle after start, cyc never asserted, pass=1. Reset asserted during RD -> cyc=0 immediately, busy=0.
- With WB_MEMTEST_ACK_TIMEOUT_EN, TIMEOUT=16, ack tied 0 -> cyc drops after 16 cycles, timeout=1, done pulse, pass=0.
